fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch stage directly upstream of the main decoder in the RV32I core. It owns the PC register and issues one instruction-memory request at a time over a valid/ready handshake. It latches the returned word and presents it to decode, with instr[6:0] driving the decoder opcode input. On decode acceptance it advances the PC to PC+4, or to the branch/jump target when the datapath asserts pc_src.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; first fetch address.
NOP_INSTR, 32'h0000_0013, value held on instr when no valid instruction (addi x0,x0,0).

Ports:
clk  in  1  core clock, all state on rising edge.
reset_n  in  1  asynchronous, active-low reset.
imem_req_valid  out  1  fetch request valid.
imem_req_ready  in  1  memory accepts request.
imem_addr  out  32  word-aligned fetch address (= pc).
imem_rsp_valid  in  1  response data valid (single cycle pulse).
imem_rsp_data  in  32  fetched instruction word.
instr_valid  out  1  instr holds an unconsumed instruction.
instr_ready  in  1  decode/execute consumes instr this cycle.
instr  out  32  latched instruction; [6:0] feeds decoder op.
instr_pc  out  32  address of instr.
instr_pc_plus4  out  32  instr_pc + 4, for jal link value.
pc_src  in  1  taken branch/jump for the accepted instr (sampled only on accept).
pc_target  in  32  redirect target (sampled only on accept).
misalign_err  out  1  sticky: redirect target not word-aligned.
proto_err  out  1  sticky: imem_rsp_valid outside WAIT.
retired  out  32  count of accepted instructions, wraps modulo 2^32.

Behaviour:
- Reset (async assert, sync release): state=FETCH, pc=RESET_PC, instr=NOP_INSTR, instr_pc=RESET_PC, instr_valid=0, imem_req_valid=0 during reset, misalign_err=0, proto_err=0, retired=0.
- States: FETCH, WAIT, HOLD, HALT.
- FETCH: imem_req_valid=1 and imem_addr=pc, both held stable until imem_req_ready. When req_valid&&req_ready -> WAIT.
- WAIT: imem_req_valid=0. On imem_rsp_valid: instr<=imem_rsp_data, instr_pc<=pc, instr_valid<=1, -> HOLD. Same-cycle response to the request is not allowed; the earliest response is the cycle after acceptance. Minimum request-to-instr_valid latency is 2 cycles.
- HOLD: instr_valid=1, and instr/instr_pc remain stable. On instr_ready:
  - retired+=1.
  - If pc_src=0, pc<=instr_pc+4.
  - If pc_src=1 and pc_target[1:0]==0, pc<=pc_target.
  - In both cases instr_valid<=0, instr<=NOP_INSTR, -> FETCH.
- If pc_src=1 and pc_target[1:0]!=0: misalign_err<=1, instr_valid<=0, -> HALT. pc is unchanged.
- HALT: no requests, instr_valid=0. Only reset exits.
- imem_rsp_valid in FETCH/HOLD/HALT: data ignored, proto_err<=1, state unaffected.
- pc_src/pc_target are don't-care unless instr_valid&&instr_ready.
- Wrap-around: PC arithmetic is 32-bit modulo 2^32. 32'hFFFF_FFFC+4 -> 0. The retired counter wraps in the same way.
- Reset mid-transaction: all state returns to reset values immediately. Any response arriving after reset release while in FETCH sets proto_err (memory must be reset with the core).
- Only one request is outstanding at a time. There is no prefetch and no speculative fetch.

Decomposition:
- Shared package (riscv_pkg): opcode constants (OP_LW, OP_SW, OP_R, OP_BEQ, OP_I, OP_JAL), NOP_INSTR, fetch state enum encoding (FETCH=2'd0, WAIT=2'd1, HOLD=2'd2, HALT=2'd3).
- One sub-module: pc_next, combinational next-PC select plus alignment check (inputs instr_pc, pc_src, pc_target; outputs next_pc, misalign). The FSM and registers stay in fetch_unit.

Test Plan:
1. Reset release, req_ready=1, 1-cycle memory returning 32'h0000_0013 -> request addr 0x0; instr_valid 2 cycles after request accept; with instr_ready=1 the next request is to addr 0x4; retired=1.
2. req_ready held 0 for 3 cycles -> imem_req_valid stays 1 and imem_addr stays 0x0 throughout; WAIT is entered only on the ready cycle.
3. instr_ready=0 for 4 cycles in HOLD -> instr, instr_pc and instr_valid stable; no new request; retired unchanged.
4. Accept with pc_src=1, pc_target=0x40 -> next request addr 0x40; instr_pc_plus4 of the jal instruction = instr_pc+4.
5. Accept with pc_src=1, pc_target=0x42 -> misalign_err=1, HALT, no further imem_req_valid until reset_n pulse.
6. RESET_PC=32'hFFFF_FFFC, accept with pc_src=0 -> next fetch addr 0x0. A spurious imem_rsp_valid in FETCH -> proto_err=1 and the fetch proceeds normally.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: decoder opcodes, the canonical NOP, and the fetch FSM encoding.
package riscv_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // addi x0,x0,0 -- what decode sees whenever no real instruction is held
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    HALT  = 2'd3
  } fetch_state_e;

  function automatic logic word_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bundle; master is the fetch unit, slave is the memory.
interface fetch_unit_if;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;

  modport master (
    output req_valid,
    output addr,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  req_valid,
    input  addr,
    output req_ready,
    output rsp_valid,
    output rsp_data
  );

endinterface

// File: rtl/fetch_unit_pc_next.sv
// Next-PC select for an accepted instruction: sequential PC+4 or redirect target, plus alignment check.
module pc_next
  import riscv_pkg::*;
(
  input  logic [31:0] instr_pc,
  input  logic        pc_src,
  input  logic [31:0] pc_target,
  output logic [31:0] next_pc,
  output logic [31:0] pc_plus4,
  output logic        misalign
);

  assign pc_plus4 = instr_pc + 32'd4;
  assign next_pc  = pc_src ? pc_target : pc_plus4;
  assign misalign = pc_src && !word_aligned(pc_target);

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch stage: owns the PC, fetches one word at a time and
// holds it for decode until accepted, then steps to PC+4 or the redirect target.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic               clk,
  input  logic               reset_n,
  fetch_unit_if.master       imem,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [31:0]        instr,
  output logic [31:0]        instr_pc,
  output logic [31:0]        instr_pc_plus4,
  input  logic               pc_src,
  input  logic [31:0]        pc_target,
  output logic               misalign_err,
  output logic               proto_err,
  output logic [31:0]        retired
);

  import riscv_pkg::*;

  fetch_state_e state_q;
  fetch_state_e state_d;
  logic [31:0]  pc_q;
  logic [31:0]  next_pc;
  logic         misalign;
  logic         accept;
  logic         rsp_take;

  pc_next u_pc_next (
    .instr_pc  (instr_pc),
    .pc_src    (pc_src),
    .pc_target (pc_target),
    .next_pc   (next_pc),
    .pc_plus4  (instr_pc_plus4),
    .misalign  (misalign)
  );

  assign accept   = (state_q == HOLD) && instr_ready;
  assign rsp_take = (state_q == WAIT) && imem.rsp_valid;
  assign imem.addr = pc_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH: if (imem.req_ready) state_d = WAIT;
      WAIT:  if (imem.rsp_valid) state_d = HOLD;
      HOLD:  if (instr_ready)    state_d = misalign ? HALT : FETCH;
      HALT:  state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // Request is masked while reset is held so memory never sees a request from a core in reset
  always_comb begin
    imem.req_valid = 1'b0;
    instr_valid    = 1'b0;
    case (state_q)
      FETCH: imem.req_valid = reset_n;
      HOLD:  instr_valid    = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q         <= RESET_PC;
      instr        <= NOP_INSTR;
      instr_pc     <= RESET_PC;
      misalign_err <= 1'b0;
      proto_err    <= 1'b0;
      retired      <= 32'd0;
    end else begin
      if (rsp_take) begin
        instr    <= imem.rsp_data;
        instr_pc <= pc_q;
      end
      // A misaligned redirect freezes the PC so the faulting context is preserved in HALT
      if (accept) begin
        retired <= retired + 32'd1;
        instr   <= NOP_INSTR;
        if (misalign) begin
          misalign_err <= 1'b1;
        end else begin
          pc_q <= next_pc;
        end
      end
      if (imem.rsp_valid && (state_q != WAIT)) begin
        proto_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: table-driven fetch transactions with a scoreboard, plus
// hand-written sequences for reset, protocol errors and PC wrap-around.
module tb_fetch_unit;
  import riscv_pkg::*;

  typedef struct {
    int          req_wait;
    int          rsp_delay;
    int          hold;
    logic        src;
    logic [31:0] tgt;
    logic        halt;
    logic [31:0] next_pc;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  fetch_unit_if m0 ();
  fetch_unit_if m1 ();

  logic        iv0, ir0, src0, me0, pe0;
  logic [31:0] in0, ipc0, ip40, tgt0, ret0;
  logic        iv1, ir1, src1, me1, pe1;
  logic [31:0] in1, ipc1, ip41, tgt1, ret1;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut0 (
    .clk(clk), .reset_n(reset_n), .imem(m0),
    .instr_valid(iv0), .instr_ready(ir0), .instr(in0), .instr_pc(ipc0),
    .instr_pc_plus4(ip40), .pc_src(src0), .pc_target(tgt0),
    .misalign_err(me0), .proto_err(pe0), .retired(ret0)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk(clk), .reset_n(reset_n), .imem(m1),
    .instr_valid(iv1), .instr_ready(ir1), .instr(in1), .instr_pc(ipc1),
    .instr_pc_plus4(ip41), .pc_src(src1), .pc_target(tgt1),
    .misalign_err(me1), .proto_err(pe1), .retired(ret1)
  );

  int          errors = 0;
  int          checks = 0;
  exp_t        sb[$];
  vec_t        vecs[7];
  logic [31:0] model_pc;
  logic [31:0] model_ret;
  logic        model_proto;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[24:0], 7'h13};
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    exp_t e;
    check_output("req_valid", {31'd0, m0.req_valid}, 32'd1);
    check_output("req_addr", m0.addr, model_pc);
    for (int k = 0; k < v.req_wait; k++) begin
      m0.req_ready = 1'b0;
      @(negedge clk);
      check_output("stall_req_valid", {31'd0, m0.req_valid}, 32'd1);
      check_output("stall_addr", m0.addr, model_pc);
    end
    m0.req_ready = 1'b1;
    @(negedge clk);
    m0.req_ready = 1'b0;
    sb.push_back('{model_pc, mem_word(model_pc)});
    check_output("wait_req_valid", {31'd0, m0.req_valid}, 32'd0);
    for (int d = 0; d < v.rsp_delay; d++) begin
      @(negedge clk);
      check_output("wait_instr_valid", {31'd0, iv0}, 32'd0);
    end
    m0.rsp_valid = 1'b1;
    m0.rsp_data  = mem_word(model_pc);
    @(negedge clk);
    m0.rsp_valid = 1'b0;
    m0.rsp_data  = 32'hDEAD_BEEF;
    check_output("instr_valid", {31'd0, iv0}, 32'd1);
    if (sb.size() == 0) begin
      errors++;
      checks++;
      $display("[TB] FAIL scoreboard_empty: got 0 entries expected 1");
      return;
    end
    e = sb.pop_front();
    check_output("instr", in0, e.word);
    check_output("instr_pc", ipc0, e.pc);
    check_output("instr_pc_plus4", ip40, e.pc + 32'd4);
    check_output("proto_err", {31'd0, pe0}, {31'd0, model_proto});
    for (int h = 0; h < v.hold; h++) begin
      ir0  = 1'b0;
      src0 = 1'($urandom);
      tgt0 = $urandom;
      @(negedge clk);
      check_output("hold_valid", {31'd0, iv0}, 32'd1);
      check_output("hold_instr", in0, e.word);
      check_output("hold_pc", ipc0, e.pc);
      check_output("hold_no_req", {31'd0, m0.req_valid}, 32'd0);
      check_output("hold_retired", ret0, model_ret);
    end
    ir0  = 1'b1;
    src0 = v.src;
    tgt0 = v.tgt;
    @(negedge clk);
    ir0  = 1'b0;
    src0 = 1'b0;
    tgt0 = 32'd0;
    check_output("instr_valid_clear", {31'd0, iv0}, 32'd0);
    if (v.halt) begin
      check_output("misalign_err", {31'd0, me0}, 32'd1);
      check_output("halt_no_req", {31'd0, m0.req_valid}, 32'd0);
    end else begin
      model_ret = model_ret + 32'd1;
      model_pc  = v.next_pc;
      check_output("retired", ret0, model_ret);
      check_output("instr_nop", in0, NOP_INSTR);
      check_output("misalign_clear", {31'd0, me0}, 32'd0);
      check_output("next_req_valid", {31'd0, m0.req_valid}, 32'd1);
      check_output("next_addr", m0.addr, model_pc);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset_n = 1'b0;
    m0.req_ready = 1'b0; m0.rsp_valid = 1'b0; m0.rsp_data = 32'd0;
    m1.req_ready = 1'b0; m1.rsp_valid = 1'b0; m1.rsp_data = 32'd0;
    ir0 = 1'b0; src0 = 1'b0; tgt0 = 32'd0;
    ir1 = 1'b0; src1 = 1'b0; tgt1 = 32'd0;
    model_pc = 32'd0; model_ret = 32'd0; model_proto = 1'b0;

    vecs[0] = '{0, 0, 0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0004};
    vecs[1] = '{3, 1, 0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0008};
    vecs[2] = '{0, 2, 4, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_000C};
    vecs[3] = '{0, 0, 1, 1'b1, 32'h0000_0040, 1'b0, 32'h0000_0040};
    vecs[4] = '{1, 0, 0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0044};
    vecs[5] = '{0, 0, 2, 1'b1, 32'h0000_1000, 1'b0, 32'h0000_1000};
    vecs[6] = '{0, 0, 0, 1'b1, 32'h0000_0042, 1'b1, 32'h0000_0000};

    repeat (2) @(negedge clk);
    check_output("rst_req_valid", {31'd0, m0.req_valid}, 32'd0);
    check_output("rst_instr", in0, NOP_INSTR);
    check_output("rst_instr_pc", ipc0, 32'h0000_0000);
    check_output("rst_instr_valid", {31'd0, iv0}, 32'd0);
    check_output("rst_errs", {30'd0, me0, pe0}, 32'd0);
    check_output("rst_retired", ret0, 32'd0);
    check_output("rst_instr_pc_1", ipc1, 32'hFFFF_FFFC);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      apply_stimulus(vecs[i]);
    end

    // HALT is terminal: no requests, and a stray response is a protocol error
    repeat (3) begin
      @(negedge clk);
      check_output("halt_req_valid", {31'd0, m0.req_valid}, 32'd0);
      check_output("halt_instr_valid", {31'd0, iv0}, 32'd0);
    end
    m0.rsp_valid = 1'b1;
    @(negedge clk);
    m0.rsp_valid = 1'b0;
    check_output("halt_proto_err", {31'd0, pe0}, 32'd1);
    check_output("halt_still_halted", {31'd0, m0.req_valid}, 32'd0);

    #2 reset_n = 1'b0;
    #1;
    check_output("async_rst_errs", {30'd0, me0, pe0}, 32'd0);
    check_output("async_rst_retired", ret0, 32'd0);
    check_output("async_rst_req_valid", {31'd0, m0.req_valid}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_output("post_rst_addr", m0.addr, 32'h0000_0000);

    // Reset during WAIT, then the memory's late response lands in FETCH
    @(negedge clk);
    m0.req_ready = 1'b1;
    @(negedge clk);
    m0.req_ready = 1'b0;
    #2 reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_output("mid_rst_req_valid", {31'd0, m0.req_valid}, 32'd1);
    check_output("mid_rst_instr_valid", {31'd0, iv0}, 32'd0);
    m0.rsp_valid = 1'b1;
    m0.rsp_data  = 32'hCAFE_F00D;
    @(negedge clk);
    m0.rsp_valid = 1'b0;
    check_output("late_rsp_proto_err", {31'd0, pe0}, 32'd1);
    check_output("late_rsp_instr_valid", {31'd0, iv0}, 32'd0);
    model_pc = 32'd0; model_ret = 32'd0; model_proto = 1'b1;
    apply_stimulus(vecs[0]);

    // PC wrap-around on the second instance
    check_output("wrap_req_valid", {31'd0, m1.req_valid}, 32'd1);
    check_output("wrap_addr", m1.addr, 32'hFFFF_FFFC);
    m1.req_ready = 1'b1;
    @(negedge clk);
    m1.req_ready = 1'b0;
    m1.rsp_valid = 1'b1;
    m1.rsp_data  = mem_word(32'hFFFF_FFFC);
    @(negedge clk);
    m1.rsp_valid = 1'b0;
    check_output("wrap_instr_valid", {31'd0, iv1}, 32'd1);
    check_output("wrap_instr_pc", ipc1, 32'hFFFF_FFFC);
    check_output("wrap_plus4", ip41, 32'h0000_0000);
    check_output("wrap_instr", in1, mem_word(32'hFFFF_FFFC));
    ir1 = 1'b1;
    @(negedge clk);
    ir1 = 1'b0;
    check_output("wrap_next_addr", m1.addr, 32'h0000_0000);
    check_output("wrap_retired", ret1, 32'd1);
    m1.rsp_valid = 1'b1;
    @(negedge clk);
    m1.rsp_valid = 1'b0;
    check_output("spurious_proto_err", {31'd0, pe1}, 32'd1);
    check_output("spurious_req_valid", {31'd0, m1.req_valid}, 32'd1);
    check_output("spurious_addr", m1.addr, 32'h0000_0000);
    m1.req_ready = 1'b1;
    @(negedge clk);
    m1.req_ready = 1'b0;
    m1.rsp_valid = 1'b1;
    m1.rsp_data  = mem_word(32'h0000_0000);
    @(negedge clk);
    m1.rsp_valid = 1'b0;
    check_output("after_spurious_valid", {31'd0, iv1}, 32'd1);
    check_output("after_spurious_pc", ipc1, 32'h0000_0000);
    check_output("after_spurious_instr", in1, mem_word(32'h0000_0000));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
